// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - host-to-FIR sequencer: setup wait, coefficient burst, sample stream, result retime
// Optional FIR_CTRL_SAT_EN: clamp results to the sample range and add sticky sat_flag.
module fir_seq_ctrl #(
    parameter int TAP_SIZE     = 3,
    parameter int NBR_OF_TAPS  = 3,
    parameter int X_N_SIZE     = 8,
    parameter int Y_N_SIZE     = 11,
    parameter int SETUP_CYCLES = 4,
    parameter int FIR_LATENCY  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [X_N_SIZE-1:0] in_data,
    input  logic                in_coef,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [X_N_SIZE-1:0] fir_x_n,
    output logic                fir_tvalid,
    output logic                fir_set_coeffs,
    input  logic [Y_N_SIZE-1:0] fir_y_n,
    output logic [Y_N_SIZE-1:0] out_data,
    output logic                out_valid,
    output logic                cfg_done,
`ifdef FIR_CTRL_SAT_EN
    output logic                sat_flag,
`endif
    output logic                busy
);

    localparam int SET_W  = $clog2(SETUP_CYCLES + 1);
    localparam int COEF_W = $clog2(NBR_OF_TAPS + 1);
    localparam logic [FIR_LATENCY-1:0] VLD_LOW = {FIR_LATENCY{1'b1}} >> 1;

    typedef enum logic [2:0] {
        WAIT_SETUP, IDLE, COLLECT, CFG_ENTER, CFG_BURST, CFG_HOLD, STREAM, DRAIN
    } state_t;

    state_t                 state, state_d;
    logic [SET_W-1:0]       setup_cnt, setup_d;
    logic [COEF_W-1:0]      coef_cnt, coef_d, shadow_idx, burst_idx;
    logic [TAP_SIZE-1:0]    shadow [NBR_OF_TAPS];
    logic [TAP_SIZE-1:0]    coef_sel;
    logic                   shadow_we;
    logic [X_N_SIZE-1:0]    x_d;
    logic                   tvalid_d, set_d, done_d, busy_d;
    logic [FIR_LATENCY-1:0] vld;
    logic [Y_N_SIZE-1:0]    result_d;
    logic                   accept;

    always_comb begin
        case (state)
            IDLE:    in_ready = 1'b1;
            COLLECT: in_ready = in_coef;
            STREAM:  in_ready = ~in_coef;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_SETUP;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            WAIT_SETUP: if (setup_cnt == SET_W'(SETUP_CYCLES - 1)) state_d = IDLE;
            IDLE: begin
                if (accept) begin
                    if (!in_coef)              state_d = STREAM;
                    else if (NBR_OF_TAPS == 1) state_d = CFG_ENTER;
                    else                       state_d = COLLECT;
                end
            end
            COLLECT:   if (accept && coef_cnt == COEF_W'(NBR_OF_TAPS - 1)) state_d = CFG_ENTER;
            CFG_ENTER: state_d = CFG_BURST;
            CFG_BURST: if (coef_cnt == COEF_W'(NBR_OF_TAPS - 1)) state_d = CFG_HOLD;
            CFG_HOLD:  state_d = IDLE;
            STREAM:    if (!accept) state_d = DRAIN;
            // Leave once the last tag will have shifted into the exit slot this edge.
            DRAIN:     if ((vld & VLD_LOW) == '0) state_d = IDLE;
            default:   state_d = WAIT_SETUP;
        endcase
    end

    always_comb begin
        setup_d    = setup_cnt;
        coef_d     = coef_cnt;
        shadow_we  = 1'b0;
        shadow_idx = coef_cnt;
        burst_idx  = '0;
        coef_sel   = '0;
        x_d        = fir_x_n;
        tvalid_d   = 1'b0;
        set_d      = 1'b0;
        done_d     = 1'b0;
        if (state == WAIT_SETUP) setup_d = setup_cnt + 1'b1;
        if (accept && in_coef) begin
            shadow_we  = 1'b1;
            shadow_idx = (state == IDLE) ? '0 : coef_cnt;
            coef_d     = shadow_idx + 1'b1;
        end
        if (accept && !in_coef) begin
            x_d      = in_data;
            tvalid_d = 1'b1;
        end
        if (state == CFG_BURST) burst_idx = coef_cnt + 1'b1;
        for (int i = 0; i < NBR_OF_TAPS; i++)
            if (burst_idx == COEF_W'(i)) coef_sel = shadow[i];
        case (state_d)
            CFG_ENTER: begin
                set_d  = 1'b1;
                x_d    = '0;
                coef_d = '0;
            end
            CFG_BURST: begin
                set_d  = 1'b1;
                x_d    = X_N_SIZE'($signed(coef_sel));
                coef_d = burst_idx;
            end
            CFG_HOLD: done_d = 1'b1;
            default:  ;
        endcase
        busy_d = (state_d != IDLE);
    end

`ifdef FIR_CTRL_SAT_EN
    localparam logic signed [Y_N_SIZE-1:0] SAT_HI = Y_N_SIZE'(2 ** (X_N_SIZE - 1) - 1);
    localparam logic signed [Y_N_SIZE-1:0] SAT_LO = Y_N_SIZE'(-(2 ** (X_N_SIZE - 1)));
    logic clip;

    always_comb begin
        result_d = fir_y_n;
        clip     = 1'b0;
        if ($signed(fir_y_n) > SAT_HI) begin
            result_d = SAT_HI;
            clip     = 1'b1;
        end else if ($signed(fir_y_n) < SAT_LO) begin
            result_d = SAT_LO;
            clip     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          sat_flag <= 1'b0;
        else if (vld[FIR_LATENCY-1] && clip) sat_flag <= 1'b1;
    end
`else
    assign result_d = fir_y_n;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            setup_cnt      <= '0;
            coef_cnt       <= '0;
            for (int i = 0; i < NBR_OF_TAPS; i++) shadow[i] <= '0;
            fir_x_n        <= '0;
            fir_tvalid     <= 1'b0;
            fir_set_coeffs <= 1'b0;
            cfg_done       <= 1'b0;
            busy           <= 1'b0;
            vld            <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
        end else begin
            setup_cnt      <= setup_d;
            coef_cnt       <= coef_d;
            for (int i = 0; i < NBR_OF_TAPS; i++)
                if (shadow_we && shadow_idx == COEF_W'(i)) shadow[i] <= in_data[TAP_SIZE-1:0];
            fir_x_n        <= x_d;
            fir_tvalid     <= tvalid_d;
            fir_set_coeffs <= set_d;
            cfg_done       <= done_d;
            busy           <= busy_d;
            // Each driven sample's tag emerges when its result is on fir_y_n.
            vld            <= (vld << 1) | FIR_LATENCY'(fir_tvalid);
            out_valid      <= vld[FIR_LATENCY-1];
            if (vld[FIR_LATENCY-1]) out_data <= result_d;
        end
    end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - scoreboard bench for fir_seq_ctrl with a behavioural 3-tap FIR fixture
`timescale 1ns/1ps
module tb_fir_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_coef = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  fir_x_n;
    logic        fir_tvalid, fir_set_coeffs;
    logic [10:0] fir_y_n;
    logic [10:0] out_data;
    logic        out_valid, cfg_done, busy;
`ifdef FIR_CTRL_SAT_EN
    logic        sat_flag;
`endif

    fir_seq_ctrl dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_coef(in_coef),
        .in_valid(in_valid), .in_ready(in_ready), .fir_x_n(fir_x_n),
        .fir_tvalid(fir_tvalid), .fir_set_coeffs(fir_set_coeffs), .fir_y_n(fir_y_n),
        .out_data(out_data), .out_valid(out_valid), .cfg_done(cfg_done),
`ifdef FIR_CTRL_SAT_EN
        .sat_flag(sat_flag),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIR fixture: shift-in coefficient load, y = c0*x[n] + c1*x[n-1] + c2*x[n-2], 2-cycle latency
    int          c0 = 0, c1 = 0, c2 = 0, h1 = 0, h2 = 0, p1 = 0;
    logic [10:0] y_q = '0;
    logic        y_force = 1'b0;
    logic [10:0] y_force_val = '0;
    always @(posedge clk) begin
        if (fir_set_coeffs) begin
            c2 <= c1; c1 <= c0; c0 <= int'($signed(fir_x_n));
        end
        if (fir_tvalid) begin
            p1 <= c0 * int'($signed(fir_x_n)) + c1 * h1 + c2 * h2;
            h1 <= int'($signed(fir_x_n)); h2 <= h1;
        end else begin
            h1 <= 0; h2 <= 0;
        end
        y_q <= 11'(p1);
    end
    assign fir_y_n = y_force ? y_force_val : y_q;

    typedef struct { logic [10:0] data; int due; } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0, checks = 0, n_ov = 0;

    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            n_ov++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got data=%0d cycle=%0d want no result", $signed(out_data), cyc);
            end else begin
                mon_e = sb.pop_front();
                if (out_data !== mon_e.data || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL out_result got data=%0d cycle=%0d want data=%0d cycle=%0d",
                             $signed(out_data), cyc, $signed(mon_e.data), mon_e.due);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_sample(input logic [7:0] d, input int y_exp);
        in_valid = 1'b1; in_coef = 1'b0; in_data = d;
        sb.push_back('{data: 11'(y_exp), due: cyc + 4});
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_coef = 1'b0; in_data = '0;
    endtask

    task automatic wait_drained(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && busy == 1'b0) begin ok = 1'b1; break; end
            step();
        end
        step(); step();
    endtask

    task automatic load_coefs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, output bit ok);
        logic [7:0] w [3];
        w[0] = a; w[1] = b; w[2] = c;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_coef = 1'b1; in_data = w[i];
            step();
        end
        idle_inputs();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy == 1'b0) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({fir_x_n, fir_tvalid, fir_set_coeffs, out_data, out_valid, cfg_done, busy, in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got x=%0h tv=%0b set=%0b od=%0h ov=%0b done=%0b busy=%0b rdy=%0b want all 0",
                     fir_x_n, fir_tvalid, fir_set_coeffs, out_data, out_valid, cfg_done, busy, in_ready);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL setup_ready cycle %0d got %0b want 0", i, in_ready);
            end
            if (i > 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL setup_busy cycle %0d got %0b want 1", i, busy);
                end
            end
            step();
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL setup_exit got rdy=%0b busy=%0b want rdy=1 busy=0", in_ready, busy);
        end
    endtask

    task automatic test_coeff_load();
        logic [7:0] xs [8];
        int n_set = 0, first_set = -1, last_set = -1, n_done = 0, done_at = -1;
        in_valid = 1'b1; in_coef = 1'b1; in_data = 8'd3; step();
        idle_inputs(); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL collect_sample_ready got %0b want 0", in_ready);
        end
        step();
        in_valid = 1'b1; in_coef = 1'b1; in_data = 8'd0; #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL collect_coef_ready got %0b want 1", in_ready);
        end
        step();
        idle_inputs(); step();
        in_valid = 1'b1; in_coef = 1'b1; in_data = 8'd3;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 0) idle_inputs();
            if (fir_set_coeffs) begin
                if (n_set == 0) first_set = i;
                last_set = i;
                if (n_set < 8) xs[n_set] = fir_x_n;
                n_set++;
            end
            if (cfg_done) begin n_done++; done_at = i; end
        end
        checks++;
        if (n_set != 4 || last_set - first_set != 3) begin
            errors++; $display("FAIL cfg_set_window got count=%0d span=%0d want count=4 span=3", n_set, last_set - first_set);
        end
        for (int k = 0; k < 4; k++) begin
            logic [7:0] want;
            want = (k == 1 || k == 3) ? 8'd3 : 8'd0;
            checks++;
            if (k >= n_set || xs[k] !== want) begin
                errors++; $display("FAIL cfg_x_n[%0d] got %0h want %0h", k, (k < n_set) ? xs[k] : 8'hxx, want);
            end
        end
        checks++;
        if (n_done != 1 || done_at != last_set + 1) begin
            errors++; $display("FAIL cfg_done got pulses=%0d at=%0d want pulses=1 at=%0d", n_done, done_at, last_set + 1);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL cfg_idle got busy=%0b rdy=%0b want busy=0 rdy=1", busy, in_ready);
        end
    endtask

    task automatic test_stream();
        int xs [5] = '{10, 20, 30, 0, 0};
        int ov0;
        bit ok;
        load_coefs(8'h01, 8'h00, 8'h01, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stream_load got busy=%0b want 0", busy); end
        ov0 = n_ov;
        for (int n = 0; n < 5; n++) begin
            drive_sample(8'(xs[n]), xs[n] + ((n >= 2) ? xs[n-2] : 0));
            step();
        end
        idle_inputs();
        wait_drained(ok);
        checks++;
        if (!ok || n_ov - ov0 != 5) begin
            errors++; $display("FAIL stream_count got %0d want 5 (drained=%0b)", n_ov - ov0, ok);
        end
    endtask

    task automatic test_drain();
        int ov0, n_busy;
        bit ok;
        ov0 = n_ov;
        drive_sample(8'd5, 5); step();
        drive_sample(8'd5, 5); step();
        idle_inputs(); step();
        checks++;
        if (fir_tvalid !== 1'b0) begin
            errors++; $display("FAIL drain_tvalid got %0b want 0", fir_tvalid);
        end
        n_busy = 0;
        while (busy && n_busy < 10) begin n_busy++; step(); end
        checks++;
        if (n_busy < 1 || n_busy > 2) begin
            errors++; $display("FAIL drain_len got %0d want 1..2", n_busy);
        end
        wait_drained(ok);
        checks++;
        if (!ok || n_ov - ov0 != 2) begin
            errors++; $display("FAIL drain_count got %0d want 2 (drained=%0b)", n_ov - ov0, ok);
        end
    endtask

    task automatic test_signed_coefs();
        int xs [3] = '{10, 20, 30};
        int cf [3] = '{-1, 1, -2};
        bit ok;
        // Upper bits of each word are ignored; taps become -1, 1, -2.
        load_coefs(8'hF7, 8'h09, 8'h0E, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL signed_load got busy=%0b want 0", busy); end
        for (int n = 0; n < 3; n++) begin
            int y = cf[2] * xs[n];
            if (n >= 1) y += cf[1] * xs[n-1];
            if (n >= 2) y += cf[0] * xs[n-2];
            drive_sample(8'(xs[n]), y);
            step();
        end
        in_valid = 1'b1; in_coef = 1'b1; in_data = 8'h01; #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL stream_coef_ready got %0b want 0", in_ready);
        end
        step();
        idle_inputs();
        wait_drained(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL signed_drain got sb=%0d want 0", sb.size()); end
    endtask

    task automatic test_result_width();
        int forced [3] = '{300, -300, 5};
        bit ok;
`ifdef FIR_CTRL_SAT_EN
        int want [3] = '{127, -128, 5};
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_initial got %0b want 0", sat_flag); end
`else
        int want [3] = '{300, -300, 5};
`endif
        for (int n = 0; n < 3; n++) begin
            y_force = 1'b1; y_force_val = 11'(forced[n]);
            drive_sample(8'd1, want[n]); step();
            idle_inputs();
            wait_drained(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL width_case%0d got sb=%0d want 0", n, sb.size()); end
`ifdef FIR_CTRL_SAT_EN
            checks++;
            if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_case%0d got %0b want 1", n, sat_flag); end
`endif
        end
        y_force = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int n_set = 0, bad = 0;
        bit hit = 1'b0;
        logic [7:0] w [3];
        w[0] = 8'd2; w[1] = 8'd1; w[2] = 8'd3;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_coef = 1'b1; in_data = w[i]; step();
        end
        idle_inputs();
        for (int i = 0; i < 10 && !hit; i++) begin
            if (fir_set_coeffs) n_set++;
            if (n_set == 2) hit = 1'b1;
            else step();
        end
        checks++;
        if (!hit || fir_x_n !== 8'd2) begin
            errors++; $display("FAIL burst_first got hit=%0b x=%0h want hit=1 x=02", hit, fir_x_n);
        end
        reset = 1'b0; #1;
        checks++;
        if ({fir_x_n, fir_tvalid, fir_set_coeffs, out_data, out_valid, cfg_done, busy, in_ready} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got x=%0h tv=%0b set=%0b od=%0h ov=%0b done=%0b busy=%0b rdy=%0b want all 0",
                     fir_x_n, fir_tvalid, fir_set_coeffs, out_data, out_valid, cfg_done, busy, in_ready);
        end
`ifdef FIR_CTRL_SAT_EN
        checks++;
        if (sat_flag !== 1'b0) begin errors++; $display("FAIL midreset_sat got %0b want 0", sat_flag); end
`endif
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (cfg_done || out_valid || fir_set_coeffs) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midreset_residue got %0d events want 0", bad); end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_recover got busy=%0b rdy=%0b want busy=0 rdy=1", busy, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_coeff_load();
        test_stream();
        test_drain();
        test_signed_coefs();
        test_result_width();
        test_reset_mid_burst();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
